// File: rtl/nn_bridge_pkg.sv
// Shared types and helpers for the NN frame bridge.
//   state_t  : bridge control states
//   sample_t : signed fixed-point word at the default width
//   cls_w()  : index width for an N-entry vector (at least 1 bit)
package nn_bridge_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef enum logic [2:0] {
    LOAD,
    FIRE,
    WAIT,
    CAP,
    DRAIN,
    RESYNC
  } state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int unsigned cls_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nn_frame_bridge_argmax.sv
// vec_argmax: combinational signed argmax over a flat vector of N words.
//   vec : N words, word i at vec[i*WIDTH +: WIDTH]
//   idx : index of the largest word; ties resolve to the lowest index
module vec_argmax
  import nn_bridge_pkg::*;
#(
  parameter int unsigned N     = 5,
  parameter int unsigned WIDTH = SAMPLE_W,
  parameter int unsigned IDX_W = cls_w(N)
) (
  input  logic [N*WIDTH-1:0] vec,
  output logic [IDX_W-1:0]   idx
);

  logic signed [WIDTH-1:0] best;

  always_comb begin
    best = $signed(vec[WIDTH-1:0]);
    idx  = '0;
    // Strict compare keeps the earliest index on ties.
    for (int unsigned i = 1; i < N; i++) begin
      if ($signed(vec[i*WIDTH +: WIDTH]) > best) begin
        best = $signed(vec[i*WIDTH +: WIDTH]);
        idx  = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/nn_frame_bridge.sv
// nn_frame_bridge: stream-side frame interface of the jet-tagging core.
//   Inbound : s_valid/s_ready/s_data/s_last feature beats are collected into
//             nn_input_data; a complete frame fires the 1-cycle nn_input_ready.
//   Outbound: nn_output_data is captured CAPTURE_DELAY cycles after
//             nn_output_ready and replayed on m_valid/m_ready/m_data with
//             m_last on the final score and m_class = argmax of the scores.
//   err_len     : 1-cycle pulse after a frame of the wrong length
//   err_timeout : 1-cycle pulse when the core does not answer in time
//   clk / reset : rising-edge clock, asynchronous active-high reset
module nn_frame_bridge
  import nn_bridge_pkg::*;
#(
  parameter int unsigned WIDTH          = SAMPLE_W,
  parameter int unsigned NFRAC          = 10,
  parameter int unsigned INPUT_SIZE     = 16,
  parameter int unsigned OUTPUT_SIZE    = 5,
  parameter int unsigned CAPTURE_DELAY  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned CLS_W         = cls_w(OUTPUT_SIZE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [WIDTH-1:0]              s_data,
  input  logic                          s_last,
  output logic                          nn_input_ready,
  output logic [WIDTH*INPUT_SIZE-1:0]   nn_input_data,
  input  logic                          nn_output_ready,
  input  logic [WIDTH*OUTPUT_SIZE-1:0]  nn_output_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [WIDTH-1:0]              m_data,
  output logic                          m_last,
  output logic [CLS_W-1:0]              m_class,
  output logic                          err_len,
  output logic                          err_timeout
);

  localparam int unsigned IDX_W  = cls_w(INPUT_SIZE);
  localparam int unsigned TCNT_W = cls_w(TIMEOUT_CYCLES);
  localparam int unsigned DCNT_W = cls_w(CAPTURE_DELAY);

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(INPUT_SIZE - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(CAPTURE_DELAY - 1);
  localparam logic [CLS_W-1:0]  K_LAST    = CLS_W'(OUTPUT_SIZE - 1);

  // NFRAC only documents the core's number format; words pass through unscaled.
  if (CAPTURE_DELAY == 0 || NFRAC >= WIDTH) begin : g_param_check
    $error("nn_frame_bridge: need CAPTURE_DELAY >= 1 and NFRAC < WIDTH");
  end

  state_t                          state, state_nxt;
  logic [IDX_W-1:0]                idx;
  logic [TCNT_W-1:0]               tcnt;
  logic [DCNT_W-1:0]               dcnt;
  logic [CLS_W-1:0]                k;
  logic [CLS_W-1:0]                cls_q, cls_d;
  logic [WIDTH*OUTPUT_SIZE-1:0]    res_buf;
  logic                            len_bad;
  logic                            to_hit;

  // Argmax runs on the word being captured so the class register loads on
  // the same edge as the result buffer and is ready with the first beat.
  vec_argmax #(
    .N     (OUTPUT_SIZE),
    .WIDTH (WIDTH),
    .IDX_W (CLS_W)
  ) u_argmax (
    .vec (nn_output_data),
    .idx (cls_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    s_ready        = 1'b0;
    nn_input_ready = 1'b0;
    m_valid        = 1'b0;
    len_bad        = 1'b0;
    to_hit         = 1'b0;
    unique case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (idx == IDX_LAST) begin
            if (s_last) begin
              state_nxt = FIRE;
            end else begin
              len_bad   = 1'b1;
              state_nxt = RESYNC;
            end
          end else if (s_last) begin
            len_bad = 1'b1;
          end
        end
      end
      RESYNC: begin
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          state_nxt = LOAD;
        end
      end
      FIRE: begin
        nn_input_ready = 1'b1;
        state_nxt      = WAIT;
      end
      WAIT: begin
        // A response arriving on the final timeout cycle still wins.
        if (nn_output_ready) begin
          state_nxt = CAP;
        end else if (tcnt == TCNT_LAST) begin
          to_hit    = 1'b1;
          state_nxt = LOAD;
        end
      end
      CAP: begin
        if (dcnt == DCNT_LAST) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        m_valid = 1'b1;
        if (m_ready && k == K_LAST) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      tcnt          <= '0;
      dcnt          <= '0;
      k             <= '0;
      cls_q         <= '0;
      res_buf       <= '0;
      nn_input_data <= '0;
      err_len       <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      err_len     <= len_bad;
      err_timeout <= to_hit;
      tcnt        <= (state == WAIT) ? tcnt + 1'b1 : '0;
      dcnt        <= (state == CAP) ? dcnt + 1'b1 : '0;

      if (state == LOAD && s_valid) begin
        nn_input_data[idx*WIDTH +: WIDTH] <= s_data;
        idx <= (s_last || idx == IDX_LAST) ? '0 : idx + 1'b1;
      end

      if (state == CAP && dcnt == DCNT_LAST) begin
        res_buf <= nn_output_data;
        cls_q   <= cls_d;
        k       <= '0;
      end

      if (m_valid && m_ready) begin
        k <= (k == K_LAST) ? '0 : k + 1'b1;
      end
    end
  end

  assign m_data  = res_buf[k*WIDTH +: WIDTH];
  assign m_last  = (state == DRAIN) && (k == K_LAST);
  assign m_class = cls_q;

endmodule
